// File: rtl/traveler_frame_uart_tx.sv
// traveler_frame_uart_tx
// Watches the traveler target-selection byte and sends every new non-zero
// value once as an 8N1-style UART frame (LSB first). There is one pending
// slot, so a change that arrives during a frame is kept. If several changes
// arrive before the slot drains, the newest value wins and overwrite pulses.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_in    target byte from upstream, held stable between changes
//   tx         UART serial line, idle high
//   busy       high from the START bit through the last STOP bit
//   frame_done one-cycle pulse in the final cycle of the last stop bit
//   overwrite  one-cycle pulse when the pending byte is replaced unsent
module traveler_frame_uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overwrite
);
    localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    localparam int BAUD_W    = $clog2(STOP_CLKS) + 1;

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);
    // frame_done is registered, so it is raised one cycle ahead of the last stop cycle
    localparam logic [BAUD_W-1:0] STOP_PRE  = BAUD_W'(STOP_CLKS - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        last_seen_reg;
    logic [7:0]        pend_data_reg;
    logic              pend_valid_reg;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;
    logic              frame_done_reg, frame_done_next;
    logic              overwrite_reg;
    logic              consume;
    logic              change;

    assign change = (data_in != last_seen_reg);

    // Output registers are loaded with the value for the next state, so tx
    // falls on the same edge that consumes the pending byte.
    always_comb begin
        state_next      = state_reg;
        baud_next       = baud_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        tx_next         = 1'b1;
        busy_next       = 1'b0;
        frame_done_next = 1'b0;
        consume         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pend_valid_reg) begin
                    consume    = 1'b1;
                    state_next = START;
                    baud_next  = '0;
                    shift_next = pend_data_reg;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                busy_next = 1'b1;
                tx_next   = 1'b0;
                if (baud_reg == BIT_LAST) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                busy_next = 1'b1;
                tx_next   = shift_reg[0];
                if (baud_reg == BIT_LAST) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_reg == STOP_LAST) begin
                    state_next = IDLE;
                    baud_next  = '0;
                end else begin
                    busy_next       = 1'b1;
                    baud_next       = baud_reg + BAUD_W'(1);
                    frame_done_next = (baud_reg == STOP_PRE);
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            baud_reg       <= '0;
            bit_reg        <= 3'd0;
            shift_reg      <= 8'h00;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            tx_reg         <= tx_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Change detection and the single pending slot. A zero byte only updates
    // last_seen and never disturbs a byte already waiting to be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen_reg  <= 8'h00;
            pend_data_reg  <= 8'h00;
            pend_valid_reg <= 1'b0;
            overwrite_reg  <= 1'b0;
        end else begin
            last_seen_reg <= data_in;
            overwrite_reg <= 1'b0;
            if (change && (data_in != 8'h00)) begin
                pend_data_reg  <= data_in;
                pend_valid_reg <= 1'b1;
                // Replacing a byte the FSM is taking this edge is not a loss
                overwrite_reg  <= pend_valid_reg && !consume;
            end else if (consume) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign overwrite  = overwrite_reg;
endmodule

// File: tb/tb_traveler_frame_uart_tx.sv
// Testbench for traveler_frame_uart_tx. Two instances run side by side with
// one and two stop bits. A transaction-level model queues the expected bytes
// and their start edges, and a monitor per instance decodes every frame.
module tb_traveler_frame_uart_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         e;
    } exp_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g
            localparam int SB = gi + 1;
            localparam int FL = (10 + SB - 1) * CPB;

            logic tx_s, busy_s, fd_s, ow_s;

            traveler_frame_uart_tx #(
                .CLKS_PER_BIT(CPB),
                .STOP_BITS   (SB)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .data_in   (data_in),
                .tx        (tx_s),
                .busy      (busy_s),
                .frame_done(fd_s),
                .overwrite (ow_s)
            );

            int         edge_cnt = 0;
            int         free_at = 0;
            int         ow_model = 0;
            int         ow_dut = 0;
            int         frames = 0;
            logic [7:0] last = 8'h00;
            logic [7:0] pdata = 8'h00;
            bit         pend = 1'b0;
            bit         cons;
            exp_t       q[$];

            // Reference model: a frame occupies FL cycles, then one idle cycle,
            // and the next waiting byte may start on the edge after that.
            initial begin
                forever begin
                    @(posedge clk);
                    edge_cnt++;
                    if (!rst_n) begin
                        last = 8'h00;
                        pdata = 8'h00;
                        pend = 1'b0;
                        free_at = 0;
                        q.delete();
                    end else begin
                        cons = pend && (edge_cnt >= free_at);
                        if (cons) begin
                            q.push_back('{pdata, edge_cnt});
                            free_at = edge_cnt + FL + 1;
                        end
                        if (data_in != last && data_in != 8'h00) begin
                            if (pend && !cons) ow_model++;
                            pend = 1'b1;
                            pdata = data_in;
                        end else if (cons) begin
                            pend = 1'b0;
                        end
                        last = data_in;
                    end
                end
            end

            initial begin
                forever begin
                    @(negedge clk);
                    if (ow_s) ow_dut++;
                end
            end

            exp_t       e;
            int         line_bad, busy_bad, fd_cnt, bidx;
            bit         fd_last, aborted;
            logic [7:0] got;
            logic       exp_line;

            initial begin
                forever begin
                    @(negedge clk);
                    if (rst_n && !tx_s) begin
                        if (q.size() == 0) begin
                            chk($sformatf("sb%0d_unexpected_frame", SB), 1, 0);
                            e = '{8'h00, edge_cnt};
                        end else begin
                            e = q.pop_front();
                        end
                        chk($sformatf("sb%0d_start_edge", SB), edge_cnt, e.e);
                        line_bad = 0; busy_bad = 0; fd_cnt = 0;
                        fd_last = 1'b0; aborted = 1'b0; got = 8'h00;
                        for (int pos = 0; pos < FL; pos++) begin
                            if (pos > 0) @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            bidx = pos / CPB;
                            if (bidx == 0) exp_line = 1'b0;
                            else if (bidx <= 8) exp_line = e.b[3'(bidx - 1)];
                            else exp_line = 1'b1;
                            if (tx_s !== exp_line) line_bad++;
                            if (busy_s !== 1'b1) busy_bad++;
                            if (fd_s) begin
                                fd_cnt++;
                                if (pos == FL - 1) fd_last = 1'b1;
                            end
                            if (bidx >= 1 && bidx <= 8 && (pos % CPB) == CPB / 2)
                                got[3'(bidx - 1)] = tx_s;
                        end
                        if (!aborted) begin
                            frames++;
                            chk($sformatf("sb%0d_byte", SB), int'(got), int'(e.b));
                            chk($sformatf("sb%0d_line_cycles_bad", SB), line_bad, 0);
                            chk($sformatf("sb%0d_busy_low_cycles", SB), busy_bad, 0);
                            chk($sformatf("sb%0d_frame_done_last", SB),
                                int'(fd_cnt == 1 && fd_last), 1);
                            @(negedge clk);
                            if (rst_n)
                                chk($sformatf("sb%0d_idle_after_frame", SB),
                                    int'({busy_s, tx_s, fd_s}), 3'b010);
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic hold(input logic [7:0] v, input int n);
        data_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_checks(input string p);
        chk({p, "_tx0"}, int'(g[0].tx_s), 1);
        chk({p, "_busy0"}, int'(g[0].busy_s), 0);
        chk({p, "_tx1"}, int'(g[1].tx_s), 1);
        chk({p, "_busy1"}, int'(g[1].busy_s), 0);
    endtask

    task automatic phase_check(input string p);
        chk({p, "_pending_exp0"}, g[0].q.size(), 0);
        chk({p, "_pending_exp1"}, g[1].q.size(), 0);
        chk({p, "_overwrites0"}, g[0].ow_dut, g[0].ow_model);
        chk({p, "_overwrites1"}, g[1].ow_dut, g[1].ow_model);
    endtask

    int f0, f1, o0, o1;

    task automatic mark();
        f0 = g[0].frames; f1 = g[1].frames;
        o0 = g[0].ow_dut; o1 = g[1].ow_dut;
    endtask

    task automatic deltas(input string p, input int nf, input int nov);
        chk({p, "_frames0"}, g[0].frames - f0, nf);
        chk({p, "_frames1"}, g[1].frames - f1, nf);
        chk({p, "_ovw_pulses0"}, g[0].ow_dut - o0, nov);
        chk({p, "_ovw_pulses1"}, g[1].ow_dut - o1, nov);
    endtask

    int         r;
    logic [7:0] v;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        idle_checks("reset");
        chk("reset_fd0", int'(g[0].fd_s), 0);
        chk("reset_ow0", int'(g[0].ow_s), 0);
        chk("reset_fd1", int'(g[1].fd_s), 0);
        chk("reset_ow1", int'(g[1].ow_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mark(); hold(8'h07, 200); deltas("single_07", 1, 0); phase_check("single_07");
        mark(); hold(8'h00, 60); deltas("zero_only", 0, 0);
        mark(); hold(8'h07, 60); deltas("resend_07", 1, 0); phase_check("resend_07");

        hold(8'h00, 5);
        mark(); hold(8'h07, 10); hold(8'h0B, 100);
        deltas("back_to_back", 2, 0); phase_check("back_to_back");

        mark(); hold(8'h07, 10); hold(8'h0B, 3); hold(8'h53, 100);
        deltas("latest_wins", 2, 1); phase_check("latest_wins");

        hold(8'h00, 5);
        mark(); hold(8'h53, 15);
        #2 rst_n = 1'b0;
        #1 idle_checks("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(8'h53, 100);
        deltas("after_reset", 1, 0); phase_check("after_reset");

        mark(); hold(8'h4F, 100); deltas("byte_4f", 1, 0); phase_check("byte_4f");

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) v = 8'h00;
            else if (r == 1) v = data_in;
            else v = 8'($urandom_range(1, 255));
            hold(v, $urandom_range(1, 60));
        end
        hold(data_in, 200);
        phase_check("random");
        chk("random_frames_seen", int'(g[0].frames > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
